// File: rtl/btb_assoc_if.sv
// Fetch/resolution bundle for the set-associative BTB.
// Master is the pipeline side and slave is the BTB.
interface btb_assoc_if #(
  parameter int XLEN = 64
) ();
  logic            lookup_valid_i;
  logic [XLEN-1:0] lookup_pc_i;
  logic            hit_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic [1:0]      pred_type_o;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic [XLEN-1:0] upd_target_i;
  logic [1:0]      upd_type_i;
  logic            upd_taken_i;
  logic            flush_i;
  logic            busy_o;

  modport master (
    output lookup_valid_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_target_i,
           upd_type_i, upd_taken_i, flush_i,
    input  hit_o, pred_taken_o, pred_target_o, pred_type_o, busy_o
  );

  modport slave (
    input  lookup_valid_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_target_i,
           upd_type_i, upd_taken_i, flush_i,
    output hit_o, pred_taken_o, pred_target_o, pred_type_o, busy_o
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters,
// round-robin replacement and a one-set-per-cycle invalidation sweep.
module btb_assoc #(
  parameter int XLEN = 64,
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  btb_assoc_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - 2 - IDX_W;
  localparam int TGT_W = XLEN - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [1:0] TYPE_BRANCH = 2'b00;

  typedef enum logic {SWEEP, READY} state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep_ptr;

  logic [WAYS-1:0]  valid_mem [SETS];
  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [TGT_W-1:0] tgt_mem   [SETS][WAYS];
  logic [1:0]       type_mem  [SETS][WAYS];
  logic [1:0]       cnt_mem   [SETS][WAYS];

  logic            hit_q;
  logic            taken_q;
  logic [XLEN-1:0] target_q;
  logic [1:0]      type_q;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, inv_any;
  logic [WAY_W-1:0] lk_way, up_way, inv_way, wr_way, rr_cur;
  logic             wr_en, wr_hit, wr_alloc;
  logic [1:0]       cur_cnt, new_cnt;
  logic             unused_bits;

  assign lk_idx = bus.lookup_pc_i[2 +: IDX_W];
  assign lk_tag = bus.lookup_pc_i[XLEN-1 -: TAG_W];
  assign up_idx = bus.upd_pc_i[2 +: IDX_W];
  assign up_tag = bus.upd_pc_i[XLEN-1 -: TAG_W];
  assign unused_bits = ^{bus.lookup_pc_i[1:0], bus.upd_pc_i[1:0], bus.upd_target_i[1:0]};

  // Descending scans so the lowest-numbered matching way is the one kept.
  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    up_hit  = 1'b0;
    up_way  = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_mem[lk_idx][w] && (tag_mem[lk_idx][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (valid_mem[up_idx][w] && (tag_mem[up_idx][w] == up_tag)) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!valid_mem[up_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    wr_en    = rst_n && (state == READY) && bus.upd_valid_i;
    wr_hit   = wr_en && up_hit;
    wr_alloc = wr_en && !up_hit && bus.upd_taken_i;
    wr_way   = up_hit ? up_way : (inv_any ? inv_way : rr_cur);
    cur_cnt  = cnt_mem[up_idx][up_way];
    new_cnt  = 2'b10;
    if (up_hit) begin
      if (bus.upd_taken_i)
        new_cnt = (cur_cnt == 2'b11) ? cur_cnt : cur_cnt + 2'b01;
      else
        new_cnt = (cur_cnt == 2'b00) ? cur_cnt : cur_cnt - 2'b01;
    end
  end

  generate
    if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_ptr [SETS];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else if (wr_alloc && !inv_any) begin
          rr_ptr[up_idx] <= rr_ptr[up_idx] + WAY_W'(1);
        end
      end
      assign rr_cur = rr_ptr[up_idx];
    end else begin : g_no_rr
      assign rr_cur = '0;
    end
  endgenerate

  // Payload arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (wr_hit || wr_alloc) begin
      tgt_mem[up_idx][wr_way]  <= bus.upd_target_i[XLEN-1:2];
      type_mem[up_idx][wr_way] <= bus.upd_type_i;
      cnt_mem[up_idx][wr_way]  <= new_cnt;
      if (wr_alloc) tag_mem[up_idx][wr_way] <= up_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SWEEP;
      sweep_ptr <= '0;
      hit_q     <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      type_q    <= TYPE_BRANCH;
    end else begin
      hit_q    <= bus.lookup_valid_i && (state == READY) && lk_hit;
      taken_q  <= (type_mem[lk_idx][lk_way] != TYPE_BRANCH) || cnt_mem[lk_idx][lk_way][1];
      target_q <= {tgt_mem[lk_idx][lk_way], 2'b00};
      type_q   <= type_mem[lk_idx][lk_way];
      case (state)
        SWEEP: begin
          valid_mem[sweep_ptr] <= '0;
          if (bus.flush_i)
            sweep_ptr <= '0;
          else if (sweep_ptr == IDX_W'(SETS-1))
            state <= READY;
          else
            sweep_ptr <= sweep_ptr + IDX_W'(1);
        end
        READY: begin
          if (wr_alloc) valid_mem[up_idx][wr_way] <= 1'b1;
          if (bus.flush_i) begin
            state     <= SWEEP;
            sweep_ptr <= '0;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

  assign bus.hit_o         = hit_q;
  assign bus.pred_taken_o  = taken_q;
  assign bus.pred_target_o = target_q;
  assign bus.pred_type_o   = type_q;
  assign bus.busy_o        = (state == SWEEP);
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage. It generalises the fixed-width single-entry-format BTB (51-bit tag, 62-bit target, `btb_type_t`, `bp_cnt_t`) to configurable XLEN, set count and associativity, and adds the following:
- a 2-bit direction counter per entry;
- round-robin replacement;
- a multi-cycle invalidation sweep on reset and flush.

Fetch issues lookups; the branch-resolution stage issues updates.

## Interface
- `XLEN`, 64, address width.
- `SETS`, 64, number of sets; power of two, ≥2.
- `WAYS`, 2, associativity; 1, 2 or 4.
- Derived: `IDX_W = $clog2(SETS)`, `TAG_W = XLEN-2-IDX_W`, `TGT_W = XLEN-2`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `lookup_valid_i` in 1: lookup request.
- `lookup_pc_i` in XLEN: fetch PC.
- `hit_o` out 1: registered lookup hit.
- `pred_taken_o` out 1: predicted taken.
- `pred_target_o` out XLEN: predicted target.
- `pred_type_o` out 2: `btb_type_t` of the hit entry.
- `upd_valid_i` in 1: resolution update.
- `upd_pc_i` in XLEN: branch PC.
- `upd_target_i` in XLEN: resolved target.
- `upd_type_i` in 2: `btb_type_t`.
- `upd_taken_i` in 1: resolved direction.
- `flush_i` in 1: invalidate all entries.
- `busy_o` out 1: sweep in progress.

## Operation
- **Addressing:** index = `pc[2 +: IDX_W]`, tag = `pc[XLEN-1 : 2+IDX_W]`. `pc[1:0]` is ignored. The stored target is `target[XLEN-1:2]`, and `pred_target_o = {stored, 2'b00}`.
- **Entry contents:** valid, tag, target, type, counter (`bp_cnt_t`).
- **State machine:** two states, SWEEP and READY.
  - SWEEP clears the valid bits of set `sweep_ptr`, one set per cycle, incrementing `sweep_ptr`.
  - At `sweep_ptr == SETS-1`, the state moves to READY.
  - `busy_o = (state == SWEEP)`.
- **Reset:** `rst_n` low forces SWEEP and `sweep_ptr = 0`. Tag, target and counter arrays are not reset.
- **Flush:** `flush_i` in READY moves to SWEEP with `sweep_ptr = 0`. `flush_i` during SWEEP restarts the sweep at set 0.
- **During SWEEP:** lookups return `hit_o = 0`; updates are dropped.
- **Lookup:**
  - All ways of the indexed set are compared. On multiple matches, the lowest way wins.
  - `pred_taken_o = cnt[1]` for BRANCH. CALL, RETURN and JUMP always give 1.
- **Update on hit (tag match):**
  - Overwrite target and type.
  - Counter saturating: +1 if taken, −1 if not, clamped to 0..3.
- **Update on miss:**
  - Allocate only if `upd_taken_i = 1`; a not-taken miss is ignored.
  - Victim is the lowest-numbered invalid way. If none is invalid, the victim is `rr_ptr[set]`, which then increments modulo WAYS.
  - `rr_ptr` advances only on pointer-chosen evictions.
  - A new entry gets counter = 2'b10.
- **`WAYS = 1`:** always replace way 0; no `rr_ptr` storage.
- **Same-set lookup and update in one cycle:** the lookup sees pre-update contents (read-before-write). The update is visible to lookups issued the next cycle.

## Timing
- **Lookup latency:** 1 cycle. A request in cycle N gives `hit_o`, `pred_*` valid in cycle N+1.
  - `hit_o = 0` in N+1 if `lookup_valid_i` was 0 in N.
  - When `hit_o = 0`, `pred_*` are don't-care but driven by registers.
- **Update:** written at the end of the issuing cycle.
- **Sweep duration:** exactly SETS cycles.
  - After `rst_n` rises, `busy_o = 1` for SETS cycles.
  - After a `flush_i` cycle, `busy_o = 1` for the following SETS cycles.
- **Reset values:** `hit_o = 0`, `pred_taken_o = 0`, `pred_target_o = 0`, `pred_type_o = BRANCH`, `busy_o = 1`, `rr_ptr = 0` for all sets.
- **Reset mid-sweep or mid-update:** any pending write is discarded and the sweep restarts.

## Test plan
Parameters: XLEN=64, SETS=64, WAYS=2.
1. Release `rst_n`; lookup every cycle → `busy_o = 1` for 64 cycles with `hit_o = 0`; `busy_o = 0` on cycle 65.
2. Update pc `0x1000`, target `0x2000`, BRANCH, taken; then lookup `0x1000` → `hit_o = 1`, `pred_taken_o = 1`, target `0x2000`. Then two not-taken updates → counter 00, `pred_taken_o = 0`, `hit_o = 1`. A third not-taken update leaves the counter at 00.
3. Not-taken update on miss for `0x3000` → no allocation; later lookup of `0x3000` gives `hit_o = 0`. A JUMP entry at `0x3004` with counter forced to 00 via not-taken updates still gives `pred_taken_o = 1`.
4. Taken updates to `0x1000`, `0x1100`, `0x1200` (all set 0):
   - Lookups of `0x1100` and `0x1200` hit; `0x1000` misses (way 0 evicted, `rr_ptr[0] → 1`).
   - A fourth taken update to `0x1300` evicts `0x1100`.
5. In the same cycle, lookup and update `0x4000` (new, taken) → `hit_o = 0` next cycle. A lookup one cycle later → `hit_o = 1`.
6. Populate 3 sets, assert `flush_i`; after 30 cycles assert `flush_i` again → `busy_o` stays 1 for 64 cycles after the second flush, and all prior PCs miss afterwards. An update during the sweep is dropped.
